// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the raw 8-bit serial link (transmitter and receiver).
//   state_t   : IDLE / SHIFT / DONE word-sequencing states
//   WORD_W    : default word width in bits
//   FIXED_DIV : enabled clock cycles per bit in fixed-rate mode
//   RATE_SEL  : index of the F bit selecting fixed (0) or programmable (1) rate
//   ORDER_SEL : index of the F bit selecting MSB-first (0) or LSB-first (1)
//   cntWidth  : width of a bit-period counter able to reach both the fixed
//               terminal count and the 4-bit programmable terminal count
// ----------------------------------------------------------------------------
package serial_pkg;

  localparam int WORD_W    = 8;
  localparam int FIXED_DIV = 16;
  localparam int RATE_SEL  = 1;
  localparam int ORDER_SEL = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The programmable terminal count is a 4-bit value, so never go below 4 bits.
  function automatic int cntWidth(input int div);
    int w;
    w = $clog2(div);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/serial_transmitter_if.sv
// ----------------------------------------------------------------------------
// serial_transmitter_if
// Word handshake and serial output bundle of the serial transmitter.
//   start     : request to send word (master -> slave)
//   word      : parallel word to send (master -> slave)
//   ready     : transmitter idle, can accept start (slave -> master)
//   busy      : a word is being shifted (slave -> master)
//   data      : serial output bit (slave -> master)
//   word_sent : one-cycle pulse after the final bit period (slave -> master)
// Modports: master (the word source), slave (the transmitter).
// ----------------------------------------------------------------------------
interface serial_transmitter_if #(
  parameter int WIDTH = serial_pkg::WORD_W
) ();

  logic             start;
  logic [WIDTH-1:0] word;
  logic             ready;
  logic             busy;
  logic             data;
  logic             word_sent;

  modport master (
    output start,
    output word,
    input  ready,
    input  busy,
    input  data,
    input  word_sent
  );

  modport slave (
    input  start,
    input  word,
    output ready,
    output busy,
    output data,
    output word_sent
  );

endinterface

// File: rtl/serial_bit_timer.sv
// ----------------------------------------------------------------------------
// serial_bit_timer
// Bit-period divider shared by both ends of the serial link. Counts enabled
// cycles and raises tick on the last cycle of each bit period.
//   clk      : system clock, rising edge
//   reset    : synchronous active-high reset
//   en       : global enable; counter holds when low
//   clear    : hold the counter at zero (used outside an active word)
//   rate_sel : 0 = FIXED_DIV cycles per bit, 1 = m+1 cycles per bit
//   m        : programmable terminal count
//   tick     : high during the final enabled cycle of a bit period
// ----------------------------------------------------------------------------
module serial_bit_timer #(
  parameter int FIXED_DIV = serial_pkg::FIXED_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clear,
  input  logic       rate_sel,
  input  logic [3:0] m,
  output logic       tick
);

  import serial_pkg::*;

  localparam int CNT_W = cntWidth(FIXED_DIV);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_terminal;

  // Terminal count depends on the selected rate; m is zero-extended.
  always_comb begin
    w_terminal = rate_sel ? CNT_W'(m) : CNT_W'(FIXED_DIV - 1);
  end

  // Tick is combinational so the owning FSM acts in the same cycle the
  // period completes; it is suppressed while disabled or cleared.
  assign tick = en & ~clear & (r_count == w_terminal);

  // Period counter: wraps to zero on tick, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (en) begin
      if (clear || tick) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_transmitter.sv
// ----------------------------------------------------------------------------
// serial_transmitter
// Parallel-to-serial transmitter for the raw serial link (no start/stop
// framing; both ends are aligned by reset and en). A word is accepted through
// a start/ready handshake and shifted out one bit per bit period.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   en    : global enable; when low every register holds
//   F     : F[1] rate select (0 fixed FIXED_DIV, 1 programmable m+1),
//           F[0] bit order (0 MSB first, 1 LSB first); latched at start
//   m     : programmable divider terminal count; latched at start
//   bus   : serial_transmitter_if.slave (start, word, ready, busy, data,
//           word_sent)
// Optional build macro TX_PARITY_EN: when defined, an even-parity bit (XOR of
// the captured word) is sent for one extra bit period after the data bits.
// ----------------------------------------------------------------------------
module serial_transmitter #(
  parameter int WIDTH     = serial_pkg::WORD_W,
  parameter int FIXED_DIV = serial_pkg::FIXED_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           F,
  input  logic [3:0]           m,
  serial_transmitter_if.slave  bus
);

  import serial_pkg::*;

`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BIT_W-1:0] r_bitCnt;
  logic             r_rateSel;
  logic             r_orderSel;
  logic [3:0]       r_m;
  logic             r_ready;
  logic             r_busy;
  logic             r_data;
  logic             r_wordSent;
`ifdef TX_PARITY_EN
  logic             r_parity;
`endif

  logic             w_tick;
  logic             w_clear;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_nextBit;
  logic             w_firstBit;

  // The divider only runs while a word is on the wire.
  assign w_clear = (r_state != SHIFT);

  serial_bit_timer #(
    .FIXED_DIV (FIXED_DIV)
  ) u_bitTimer (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (w_clear),
    .rate_sel (r_rateSel),
    .m        (r_m),
    .tick     (w_tick)
  );

  // Shift toward the output end with zero fill; the next bit to present is
  // whatever lands on the output end after the shift.
  always_comb begin
    w_shiftNext = r_orderSel ? (r_shift >> 1) : (r_shift << 1);
    w_nextBit   = r_orderSel ? w_shiftNext[0] : w_shiftNext[WIDTH-1];
    w_firstBit  = F[ORDER_SEL] ? bus.word[0] : bus.word[WIDTH-1];
  end

  // Word sequencer with registered outputs. data is loaded one cycle ahead
  // so the first bit is already on the wire in the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_rateSel  <= 1'b0;
      r_orderSel <= 1'b0;
      r_m        <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_data     <= 1'b0;
      r_wordSent <= 1'b0;
`ifdef TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (en) begin
      case (r_state)
        IDLE: begin
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
          r_data     <= 1'b0;
          r_wordSent <= 1'b0;
          if (bus.start) begin
            r_state    <= SHIFT;
            r_shift    <= bus.word;
            r_bitCnt   <= '0;
            r_rateSel  <= F[RATE_SEL];
            r_orderSel <= F[ORDER_SEL];
            r_m        <= m;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_data     <= w_firstBit;
`ifdef TX_PARITY_EN
            r_parity   <= ^bus.word;
`endif
          end
        end

        SHIFT: begin
          if (w_tick) begin
            r_shift  <= w_shiftNext;
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == BIT_W'(FRAME_BITS - 1)) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_data     <= 1'b0;
              r_wordSent <= 1'b1;
`ifdef TX_PARITY_EN
            end else if (r_bitCnt == BIT_W'(WIDTH - 1)) begin
              r_data <= r_parity;
`endif
            end else begin
              r_data <= w_nextBit;
            end
          end
        end

        DONE: begin
          r_state    <= IDLE;
          r_bitCnt   <= '0;
          r_wordSent <= 1'b0;
          r_ready    <= 1'b1;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.data      = r_data;
  assign bus.word_sent = r_wordSent;

endmodule

// File: tb/tb_serial_transmitter.sv
// ----------------------------------------------------------------------------
// tb_serial_transmitter
// Self-checking bench for serial_transmitter. Expected serial bits are pushed
// into a queue when a word is started and popped as the frame is observed.
// Build with +define+TX_PARITY_EN to cover the parity-bit variant.
// ----------------------------------------------------------------------------
module tb_serial_transmitter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] F;
  logic [3:0] m;

  int checks;
  int passes;

  logic expBits[$];

  serial_transmitter_if #(.WIDTH(8)) bus ();

  serial_transmitter #(
    .WIDTH     (8),
    .FIXED_DIV (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .F     (F),
    .m     (m),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model: expected wire bits of one frame in transmit order.
  task automatic pushBits(input logic [7:0] w, input logic lsbFirst);
    for (int i = 0; i < 8; i++) begin
      expBits.push_back(lsbFirst ? w[i] : w[7-i]);
    end
`ifdef TX_PARITY_EN
    expBits.push_back(^w);
`endif
  endtask

  // Offer one word from IDLE, then scramble the inputs to prove latching.
  task automatic startFrame(input logic [7:0] w, input logic [1:0] f, input logic [3:0] mm);
    bus.word  = w;
    F         = f;
    m         = mm;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.word  = ~w;
    F         = ~f;
    m         = mm + 4'd5;
    pushBits(w, f[0]);
  endtask

  // Observe a frame starting at the first-bit cycle: every bit cycle, then
  // the word_sent cycle, ending with the ready cycle sampled (no final tick).
  task automatic checkFrame(input int period, input string name, input int pulseAt);
    int n;
    int nBits;
    logic expBit;
    n = 1;
    nBits = expBits.size();
    for (int b = 0; b < nBits; b++) begin
      expBit = expBits.pop_front();
      for (int c = 0; c < period; c++) begin
        checks++;
        if (bus.data !== expBit || bus.busy !== 1'b1 || bus.ready !== 1'b0 || bus.word_sent !== 1'b0)
          $display("[TB] FAIL %s bit%0d cycle%0d: data=%b busy=%b ready=%b sent=%b, expected data=%b busy=1 ready=0 sent=0",
                   name, b, n, bus.data, bus.busy, bus.ready, bus.word_sent, expBit);
        else
          passes++;
        if (pulseAt != 0 && n == pulseAt) begin
          bus.start = 1'b1;
          bus.word  = 8'h3C;
        end else if (pulseAt != 0 && n == pulseAt + 1) begin
          bus.start = 1'b0;
        end
        tick();
        n++;
      end
    end
    checks++;
    if (bus.word_sent !== 1'b1 || bus.busy !== 1'b0 || bus.data !== 1'b0 || bus.ready !== 1'b0)
      $display("[TB] FAIL %s done cycle%0d: sent=%b busy=%b data=%b ready=%b, expected sent=1 busy=0 data=0 ready=0",
               name, n, bus.word_sent, bus.busy, bus.data, bus.ready);
    else
      passes++;
    tick();
    n++;
    checks++;
    if (bus.ready !== 1'b1 || bus.word_sent !== 1'b0 || bus.busy !== 1'b0)
      $display("[TB] FAIL %s ready cycle%0d: ready=%b sent=%b busy=%b, expected ready=1 sent=0 busy=0",
               name, n, bus.ready, bus.word_sent, bus.busy);
    else
      passes++;
  endtask

  // Reset asserted together with start: reset must win.
  task automatic test_reset();
    reset     = 1'b1;
    en        = 1'b1;
    F         = 2'b00;
    m         = 4'd0;
    bus.start = 1'b1;
    bus.word  = 8'hA5;
    tick();
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.ready !== 1'b1) $display("[TB] FAIL reset ready: got %b expected 1", bus.ready); else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); else passes++;
    checks++;
    if (bus.data !== 1'b0) $display("[TB] FAIL reset data: got %b expected 0", bus.data); else passes++;
    checks++;
    if (bus.word_sent !== 1'b0) $display("[TB] FAIL reset word_sent: got %b expected 0", bus.word_sent); else passes++;
  endtask

  task automatic test_msb_fixed();
    startFrame(8'hA5, 2'b00, 4'd0);
    checkFrame(16, "msb_fixed", 0);
  endtask

  task automatic test_lsb_prog();
    startFrame(8'hA5, 2'b11, 4'd2);
    checkFrame(3, "lsb_prog", 0);
  endtask

  // en alternates during the frame: bits only advance on enabled cycles and
  // a pending word_sent holds while disabled.
  task automatic test_enable_gating();
    int nBits;
    logic expBit;
    startFrame(8'h5A, 2'b10, 4'd0);
    nBits = expBits.size();
    for (int b = 0; b < nBits; b++) begin
      expBit = expBits.pop_front();
      checks++;
      if (bus.data !== expBit || bus.busy !== 1'b1)
        $display("[TB] FAIL en_gate bit%0d: data=%b busy=%b, expected data=%b busy=1", b, bus.data, bus.busy, expBit);
      else
        passes++;
      en = 1'b0;
      tick();
      checks++;
      if (bus.data !== expBit || bus.busy !== 1'b1 || bus.word_sent !== 1'b0)
        $display("[TB] FAIL en_gate hold%0d: data=%b busy=%b sent=%b, expected data=%b busy=1 sent=0",
                 b, bus.data, bus.busy, bus.word_sent, expBit);
      else
        passes++;
      en = 1'b1;
      tick();
    end
    checks++;
    if (bus.word_sent !== 1'b1) $display("[TB] FAIL en_gate word_sent: got %b expected 1", bus.word_sent); else passes++;
    en = 1'b0;
    tick();
    checks++;
    if (bus.word_sent !== 1'b1 || bus.ready !== 1'b0)
      $display("[TB] FAIL en_gate frozen done: sent=%b ready=%b expected sent=1 ready=0", bus.word_sent, bus.ready);
    else
      passes++;
    en = 1'b1;
    tick();
    checks++;
    if (bus.word_sent !== 1'b0 || bus.ready !== 1'b1)
      $display("[TB] FAIL en_gate release: sent=%b ready=%b expected sent=0 ready=1", bus.word_sent, bus.ready);
    else
      passes++;
  endtask

  // Abort mid-word, then reset-with-start, then a clean follow-up word.
  task automatic test_reset_mid_word();
    startFrame(8'hFF, 2'b00, 4'd0);
    expBits.delete();
    for (int i = 0; i < 64; i++) tick();
    checks++;
    if (bus.data !== 1'b1 || bus.busy !== 1'b1)
      $display("[TB] FAIL abort pre bit4: data=%b busy=%b expected data=1 busy=1", bus.data, bus.busy);
    else
      passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.data !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.word_sent !== 1'b0)
      $display("[TB] FAIL abort: data=%b ready=%b busy=%b sent=%b expected 0 1 0 0",
               bus.data, bus.ready, bus.busy, bus.word_sent);
    else
      passes++;
    bus.start = 1'b1;
    bus.word  = 8'hAA;
    tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0)
      $display("[TB] FAIL reset_vs_start: ready=%b busy=%b expected ready=1 busy=0", bus.ready, bus.busy);
    else
      passes++;
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.word_sent !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1)
        $display("[TB] FAIL abort idle%0d: sent=%b busy=%b ready=%b expected 0 0 1",
                 i, bus.word_sent, bus.busy, bus.ready);
      else
        passes++;
    end
    startFrame(8'h0F, 2'b11, 4'd1);
    checkFrame(2, "after_abort", 0);
  endtask

  // start held high: two frames with one DONE and one IDLE cycle between;
  // a stray start during the second frame must not queue a third.
  task automatic test_back_to_back();
    bus.word  = 8'h81;
    F         = 2'b10;
    m         = 4'd1;
    bus.start = 1'b1;
    tick();
    pushBits(8'h81, 1'b0);
    checkFrame(2, "b2b_first", 0);
    tick();
    bus.start = 1'b0;
    pushBits(8'h81, 1'b0);
    checkFrame(2, "b2b_second", 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.ready !== 1'b1)
        $display("[TB] FAIL b2b no_queue%0d: busy=%b ready=%b expected busy=0 ready=1", i, bus.busy, bus.ready);
      else
        passes++;
    end
  endtask

  task automatic test_parity_frame();
    startFrame(8'h07, 2'b10, 4'd0);
    checkFrame(1, "parity_frame", 0);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    reset     = 1'b1;
    en        = 1'b1;
    F         = 2'b00;
    m         = 4'd0;
    bus.start = 1'b0;
    bus.word  = 8'h00;
    test_reset();
    test_msb_fixed();
    tick();
    test_lsb_prog();
    tick();
    test_enable_gating();
    tick();
    test_reset_mid_word();
    tick();
    test_back_to_back();
    tick();
    test_parity_frame();
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
